// File: rtl/station_cmd_pkg.sv
// Shared constants for the station command processor and the barcode reader.
// Holds the station-ID field layout, the command opcodes and the FSM states.
package station_cmd_pkg;

   // Station-ID / command byte layout: [7:6] opcode, [5:0] station
   localparam int unsigned OP_W  = 2;
   localparam int unsigned STN_W = 6;
   localparam int unsigned ID_W  = OP_W + STN_W;
   localparam int unsigned CNT_W = 16;

   // Command opcodes; the remaining two encodings are reserved
   localparam logic [OP_W-1:0] OP_STOP = 2'b00;
   localparam logic [OP_W-1:0] OP_GO   = 2'b01;

   // FSM states
   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] TRANSIT = 1'b1;

endpackage

// File: rtl/buzz_gen.sv
// Piezo buzzer driver: square wave of period 2*BUZZ_HALF while en is high.
// The first half-period after enabling is silent; both drives are low when disabled.
// Ports: clk, rst_n (async active-low), en (buzzer request), buzz / buzz_n (piezo drive pair).
module buzz_gen
   import station_cmd_pkg::*;
#(
   parameter int unsigned BUZZ_HALF = 12500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic buzz,
   output logic buzz_n
);

   logic [CNT_W-1:0] cnt;
   logic             term;

   assign term = (cnt == CNT_W'(BUZZ_HALF - 1));

   // Half-period counter and drive pair; buzz_n takes the old buzz on each toggle
   // so it stays low through the silent first half-period, then complements buzz.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         buzz   <= 1'b0;
         buzz_n <= 1'b0;
      end else if (!en) begin
         cnt    <= '0;
         buzz   <= 1'b0;
         buzz_n <= 1'b0;
      end else if (term) begin
         cnt    <= '0;
         buzz   <= ~buzz;
         buzz_n <= buzz;
      end else begin
         cnt    <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/station_cmd.sv
// Station command processor: accepts GO/STOP commands, tracks the destination
// station, stops on a matching barcode ID and buzzes while obstructed in transit.
// Ports: clk, rst_n; cmd/cmd_rdy -> clr_cmd_rdy; ID/ID_vld -> clr_ID_vld;
//        ok2move in; go, in_transit, buzz, buzz_n out.
module station_cmd
   import station_cmd_pkg::*;
#(
   parameter int unsigned BUZZ_HALF = 12500
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ID_W-1:0] cmd,
   input  logic            cmd_rdy,
   output logic            clr_cmd_rdy,
   input  logic [ID_W-1:0] ID,
   input  logic            ID_vld,
   output logic            clr_ID_vld,
   input  logic            ok2move,
   output logic            go,
   output logic            in_transit,
   output logic            buzz,
   output logic            buzz_n
);

   logic [0:0]       state;
   logic [0:0]       next_state;
   logic [STN_W-1:0] dest;
   logic [STN_W-1:0] next_dest;
   logic [OP_W-1:0]  op;
   logic             id_match;

   assign op       = cmd[ID_W-1:STN_W];
   assign id_match = (ID[ID_W-1:STN_W] == OP_W'(0)) && (ID[STN_W-1:0] == dest);

   // Every pending item is consumed the cycle it is seen
   assign clr_cmd_rdy = cmd_rdy;
   assign clr_ID_vld  = ID_vld;

   assign in_transit = (state == TRANSIT);
   assign go         = in_transit & ok2move;

   // State and destination registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         dest  <= '0;
      end else begin
         state <= next_state;
         dest  <= next_dest;
      end
   end

   // Next-state logic; a command takes priority and discards a simultaneous ID
   always_comb begin
      next_state = state;
      next_dest  = dest;
      case (state)
         IDLE: begin
            if (cmd_rdy && (op == OP_GO)) begin
               next_dest  = cmd[STN_W-1:0];
               next_state = TRANSIT;
            end
         end
         TRANSIT: begin
            if (cmd_rdy) begin
               if (op == OP_STOP) begin
                  next_state = IDLE;
               end else if (op == OP_GO) begin
                  next_dest = cmd[STN_W-1:0];
               end
            end else if (ID_vld && id_match) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   buzz_gen #(
      .BUZZ_HALF(BUZZ_HALF)
   ) u_buzz (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_transit & ~ok2move),
      .buzz  (buzz),
      .buzz_n(buzz_n)
   );

endmodule
